// File: rtl/img_pkg.sv
// Shared definitions for the camera pixel path: pixel/coordinate widths and capture states.
package img_pkg;

  localparam int PIX_W   = 12;
  localparam int COORD_W = 11;
  localparam int FCNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } cap_state_t;

endpackage

// File: rtl/sensor_frame_capture_if.sv
// Pixel bundle between the sensor side (raw pixel plus strobes) and the capture block
// (qualified pixel plus coordinates).
interface sensor_frame_capture_if #(
  parameter int PIX_W   = img_pkg::PIX_W,
  parameter int COORD_W = img_pkg::COORD_W
);

  logic [PIX_W-1:0]   iDATA;
  logic               iFVAL;
  logic               iLVAL;
  logic [PIX_W-1:0]   oDATA;
  logic               oDVAL;
  logic [COORD_W-1:0] oX_Cont;
  logic [COORD_W-1:0] oY_Cont;

  modport master (
    output iDATA, iFVAL, iLVAL,
    input  oDATA, oDVAL, oX_Cont, oY_Cont
  );

  modport slave (
    input  iDATA, iFVAL, iLVAL,
    output oDATA, oDVAL, oX_Cont, oY_Cont
  );

endinterface

// File: rtl/sensor_frame_capture_sig_edge.sv
// Registered edge detector: keeps the previous sample of sig_i and flags its
// rising and falling transitions against the current sample.
module sig_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic prev_q;

  // Delayed copy of the input for edge comparison.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;
  assign fall_o = ~sig_i & prev_q;

endmodule

// File: rtl/sensor_frame_capture.sv
// Sensor front end: qualifies raw pixels with frame/line valid, gates capture to whole
// frames under start/stop control and emits pixel, X/Y coordinates and a frame count.
module sensor_frame_capture #(
  parameter int PIX_W    = img_pkg::PIX_W,
  parameter int COORD_W  = img_pkg::COORD_W,
  parameter int LINE_LEN = 1280,
  parameter int FCNT_W   = img_pkg::FCNT_W
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  sensor_frame_capture_if.slave pix_if,
  input  logic                  iSTART,
  input  logic                  iEND,
  output logic [FCNT_W-1:0]     oFrame_Cont,
  output logic                  oLine_err
);

  import img_pkg::*;

  localparam logic [COORD_W-1:0] C_ZERO = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] C_ONE  = COORD_W'(1);
  localparam logic [COORD_W-1:0] C_MAX  = {COORD_W{1'b1}};
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(LINE_LEN - 1);
  localparam logic [FCNT_W-1:0]  F_ONE  = FCNT_W'(1);

  // Row counter stops at its maximum instead of wrapping.
  function automatic logic [COORD_W-1:0] y_step(input logic [COORD_W-1:0] y);
    if (y == C_MAX) begin
      return y;
    end else begin
      return y + C_ONE;
    end
  endfunction

  logic [PIX_W-1:0]   data_s1_q;
  logic               fval_s1_q;
  logic               lval_s1_q;
  logic               fval_rise_s;
  logic               fval_fall_s;
  logic               lval_fall_s;
  logic               lval_rise_unused_s;

  logic               run_q, run_d;
  cap_state_t         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [FCNT_W-1:0]  frame_q, frame_d;
  logic               lerr_q, lerr_d;
  logic               pv_s;
  logic               frame_start_s;

  logic [PIX_W-1:0]   odata_q;
  logic               dval_q;
  logic [COORD_W-1:0] ox_q;
  logic [COORD_W-1:0] oy_q;

  // Stage 1: register the raw sensor inputs every cycle.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      data_s1_q <= {PIX_W{1'b0}};
      fval_s1_q <= 1'b0;
      lval_s1_q <= 1'b0;
    end else begin
      data_s1_q <= pix_if.iDATA;
      fval_s1_q <= pix_if.iFVAL;
      lval_s1_q <= pix_if.iLVAL;
    end
  end

  sig_edge u_fval_edge (
    .clk_i  (iCLK),
    .rst_ni (iRST),
    .sig_i  (fval_s1_q),
    .rise_o (fval_rise_s),
    .fall_o (fval_fall_s)
  );

  sig_edge u_lval_edge (
    .clk_i  (iCLK),
    .rst_ni (iRST),
    .sig_i  (lval_s1_q),
    .rise_o (lval_rise_unused_s),
    .fall_o (lval_fall_s)
  );

  // Run flag next value; a stop request overrides a simultaneous start.
  always_comb begin
    run_d = run_q;
    if (iEND) begin
      run_d = 1'b0;
    end else if (iSTART) begin
      run_d = 1'b1;
    end else begin
      run_d = run_q;
    end
  end

  // Capture FSM next state: frames are only entered on a fresh frame-valid edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (run_q) begin
          state_d = ARMED;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (!run_q) begin
          state_d = IDLE;
        end else if (fval_rise_s) begin
          state_d = ACTIVE;
        end else begin
          state_d = ARMED;
        end
      end
      ACTIVE: begin
        if (fval_fall_s) begin
          state_d = run_q ? ARMED : IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pv_s          = (state_q == ACTIVE) & fval_s1_q & lval_s1_q;
  assign frame_start_s = (state_q == ARMED) & run_q & fval_rise_s;

  // Coordinate counters, short-line detection and frame counting.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    lerr_d  = 1'b0;
    frame_d = frame_q;
    if (frame_start_s) begin
      x_d = C_ZERO;
      y_d = C_ZERO;
    end else if (pv_s) begin
      if (x_q == X_LAST) begin
        x_d = C_ZERO;
        y_d = y_step(y_q);
      end else begin
        x_d = x_q + C_ONE;
      end
    end else if ((state_q == ACTIVE) && lval_fall_s && (x_q != C_ZERO)) begin
      // A line that ended part-way still consumes a row.
      x_d    = C_ZERO;
      y_d    = y_step(y_q);
      lerr_d = 1'b1;
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
    if ((state_q == ACTIVE) && fval_fall_s) begin
      frame_d = frame_q + F_ONE;
    end else begin
      frame_d = frame_q;
    end
  end

  // Control state, counters and the line-error pulse.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      run_q   <= 1'b0;
      state_q <= IDLE;
      x_q     <= {COORD_W{1'b0}};
      y_q     <= {COORD_W{1'b0}};
      frame_q <= {FCNT_W{1'b0}};
      lerr_q  <= 1'b0;
    end else begin
      run_q   <= run_d;
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
      lerr_q  <= lerr_d;
    end
  end

  // Stage 2: pixel and coordinates update only on a qualified pixel, otherwise hold.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      odata_q <= {PIX_W{1'b0}};
      dval_q  <= 1'b0;
      ox_q    <= {COORD_W{1'b0}};
      oy_q    <= {COORD_W{1'b0}};
    end else begin
      dval_q <= pv_s;
      if (pv_s) begin
        odata_q <= data_s1_q;
        ox_q    <= x_q;
        oy_q    <= y_q;
      end else begin
        odata_q <= odata_q;
        ox_q    <= ox_q;
        oy_q    <= oy_q;
      end
    end
  end

  assign pix_if.oDATA   = odata_q;
  assign pix_if.oDVAL   = dval_q;
  assign pix_if.oX_Cont = ox_q;
  assign pix_if.oY_Cont = oy_q;
  assign oFrame_Cont    = frame_q;
  assign oLine_err      = lerr_q;

endmodule

// File: tb/tb_sensor_frame_capture.sv
// Scoreboard bench for sensor_frame_capture: frames of randomized line lengths are driven,
// expected beats are derived per line from LINE_LEN arithmetic, and a monitor checks them.
module tb_sensor_frame_capture;

  localparam int LL   = 4;
  localparam int PW   = 12;
  localparam int CW   = 11;
  localparam int FW   = 32;
  localparam int YMAX = (1 << CW) - 1;

  typedef struct {
    logic [PW-1:0] d;
    int            x;
    int            y;
    int            t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [FW-1:0] fcnt;
  logic          lerr;

  sensor_frame_capture_if #(.PIX_W(PW), .COORD_W(CW)) pif ();

  sensor_frame_capture #(
    .PIX_W(PW), .COORD_W(CW), .LINE_LEN(LL), .FCNT_W(FW)
  ) dut (
    .iCLK        (clk),
    .iRST        (rst_n),
    .pix_if      (pif.slave),
    .iSTART      (start),
    .iEND        (stop),
    .oFrame_Cont (fcnt),
    .oLine_err   (lerr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t          q[$];
  int            line_q[$];
  int            total = 0;
  int            bad = 0;
  int            lerr_seen = 0;
  int            exp_lerr = 0;
  int            exp_frames = 0;
  bit            run_m = 1'b0;
  bit            cap_m = 1'b0;
  bit            pend_start = 1'b0;
  bit            pend_stop = 1'b0;
  bit            seq_mode = 1'b0;
  logic [PW-1:0] last_d = '0;
  int            last_x = 0;
  int            last_y = 0;

  // Monitor: every valid beat is popped from the scoreboard; idle cycles must hold the last beat.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (lerr) lerr_seen++;
      if (pif.oDVAL) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_dval: got d=%h x=%0d y=%0d at cycle %0d, want no beat",
                   pif.oDATA, pif.oX_Cont, pif.oY_Cont, cyc);
        end else begin
          e = q.pop_front();
          if (pif.oDATA !== e.d || int'(pif.oX_Cont) != e.x || int'(pif.oY_Cont) != e.y || cyc != e.t) begin
            bad++;
            $display("FAIL beat: got d=%h x=%0d y=%0d cyc=%0d, want d=%h x=%0d y=%0d cyc=%0d",
                     pif.oDATA, pif.oX_Cont, pif.oY_Cont, cyc, e.d, e.x, e.y, e.t);
          end
          last_d = e.d;
          last_x = e.x;
          last_y = e.y;
        end
      end else begin
        total++;
        if (pif.oDATA !== last_d || int'(pif.oX_Cont) != last_x || int'(pif.oY_Cont) != last_y) begin
          bad++;
          $display("FAIL hold: got d=%h x=%0d y=%0d, want d=%h x=%0d y=%0d",
                   pif.oDATA, pif.oX_Cont, pif.oY_Cont, last_d, last_x, last_y);
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic [PW-1:0] d, input logic f, input logic l,
                       input bit push, input int xx, input int yy);
    @(posedge clk);
    #1;
    pif.iDATA = d;
    pif.iFVAL = f;
    pif.iLVAL = l;
    start = pend_start;
    stop  = pend_stop;
    if (pend_stop) run_m = 1'b0;
    else if (pend_start) run_m = 1'b1;
    pend_start = 1'b0;
    pend_stop  = 1'b0;
    if (push) q.push_back('{d: d, x: xx, y: yy, t: cyc + 2});
  endtask

  // Vertical blanking with stray line-valid pulses that must be ignored.
  task automatic idle(input int n);
    repeat (n) drive(PW'($urandom), 1'b0, 1'($urandom & 1), 1'b0, 0, 0);
  endtask

  task automatic check_zero(input string name);
    total++;
    if (pif.oDVAL !== 1'b0 || pif.oDATA !== '0 || pif.oX_Cont !== '0 || pif.oY_Cont !== '0 ||
        fcnt !== '0 || lerr !== 1'b0) begin
      bad++;
      $display("FAIL %s: got dval=%b d=%h x=%0d y=%0d fcnt=%0d lerr=%b, want all zero",
               name, pif.oDVAL, pif.oDATA, pif.oX_Cont, pif.oY_Cont, fcnt, lerr);
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    q.delete();
    cap_m      = 1'b0;
    run_m      = 1'b0;
    exp_frames = 0;
    last_d     = '0;
    last_x     = 0;
    last_y     = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // kind: 0 none, 1 start pulse, 2 end pulse, 3 reset; applied at line at_line.
  task automatic frame(input int kind, input int at_line);
    int ybase, pix, yy, len;
    logic [PW-1:0] dat;
    cap_m = run_m;
    ybase = 0;
    pix   = 0;
    drive(PW'($urandom), 1'b1, 1'b0, 1'b0, 0, 0);
    drive(PW'($urandom), 1'b1, 1'b0, 1'b0, 0, 0);
    foreach (line_q[li]) begin
      len = line_q[li];
      for (int p = 0; p < len; p++) begin
        if (li == at_line && p == 0) begin
          if (kind == 1) pend_start = 1'b1;
          if (kind == 2) pend_stop = 1'b1;
        end
        dat = seq_mode ? PW'(32'h100 + pix) : PW'($urandom);
        yy  = ybase + p / LL;
        if (yy > YMAX) yy = YMAX;
        drive(dat, 1'b1, 1'b1, cap_m, p % LL, yy);
        if (kind == 3 && li == at_line && p == 1) do_reset();
        pix++;
      end
      if (cap_m) begin
        ybase += len / LL + ((len % LL != 0) ? 1 : 0);
        if (len % LL != 0) exp_lerr++;
      end
      drive(PW'($urandom), 1'b1, 1'b0, 1'b0, 0, 0);
      drive(PW'($urandom), 1'b1, 1'b0, 1'b0, 0, 0);
    end
    drive(PW'($urandom), 1'b0, 1'b0, 1'b0, 0, 0);
    if (cap_m) exp_frames++;
  endtask

  task automatic check_point(input string name);
    total++;
    if (fcnt !== FW'(exp_frames)) begin
      bad++;
      $display("FAIL %s_frames: got %0d, want %0d", name, fcnt, exp_frames);
    end
    total++;
    if (lerr_seen != exp_lerr) begin
      bad++;
      $display("FAIL %s_line_err: got %0d pulses, want %0d", name, lerr_seen, exp_lerr);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_beats: got %0d undelivered, want 0", name, q.size());
    end
  endtask

  initial begin : stim
    int n, r, k, kind;
    pif.iDATA = '0;
    pif.iFVAL = 1'b0;
    pif.iLVAL = 1'b0;
    @(posedge clk);
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Whole frame, 3 lines of LINE_LEN, sequential data.
    seq_mode = 1'b1;
    pend_start = 1'b1;
    idle(6);
    line_q = '{4, 4, 4};
    frame(0, -1);
    idle(6);
    check_point("basic");
    seq_mode = 1'b0;

    // Start arriving mid-frame: that frame is skipped, the next is captured.
    pend_stop = 1'b1;
    idle(6);
    frame(1, 1);
    idle(6);
    check_point("mid_start");
    frame(0, -1);
    idle(6);
    check_point("after_mid_start");

    // Short second line.
    line_q = '{4, 2, 4};
    frame(0, -1);
    idle(6);
    check_point("short_line");

    // End mid-frame completes the frame; simultaneous start+end stays idle.
    line_q = '{4, 4, 4};
    frame(2, 1);
    idle(6);
    check_point("mid_end");
    frame(0, -1);
    idle(6);
    check_point("after_end");
    pend_start = 1'b1;
    pend_stop  = 1'b1;
    idle(6);
    frame(0, -1);
    idle(6);
    check_point("start_end_same");

    // Reset in the middle of a line, then two frames without start.
    pend_start = 1'b1;
    idle(6);
    frame(3, 1);
    idle(6);
    frame(0, -1);
    idle(6);
    frame(0, -1);
    idle(6);
    check_point("mid_reset");

    // Armed with stray line-valid pulses in blanking.
    pend_start = 1'b1;
    idle(30);
    check_point("stray_lval");

    // Randomized frames and control.
    repeat (24) begin
      r = $urandom_range(0, 9);
      if (r < 3) pend_start = 1'b1;
      else if (r == 3) pend_stop = 1'b1;
      else if (r == 4) begin
        pend_start = 1'b1;
        pend_stop  = 1'b1;
      end
      idle(6);
      line_q.delete();
      n = $urandom_range(1, 4);
      repeat (n) line_q.push_back($urandom_range(1, 9));
      k = $urandom_range(0, 5);
      kind = (k == 1) ? 1 : ((k == 2) ? 2 : 0);
      frame(kind, $urandom_range(0, n - 1));
      idle(6);
      check_point("rand");
    end

    // Row counter saturation: more single-pixel lines than the Y range holds.
    pend_start = 1'b1;
    idle(6);
    line_q.delete();
    repeat (YMAX + 3) line_q.push_back(1);
    frame(0, -1);
    idle(6);
    check_point("y_saturate");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sensor_frame_capture.md
Name: sensor_frame_capture

Overview:
Front end of the camera pixel path. It qualifies raw sensor pixels using the sensor frame-valid and line-valid strobes, and gates capture to whole frames under start/stop control. It produces the pixel stream, data-valid and X/Y coordinates consumed by the image-processing stage (line buffer, greyscale, convolution), plus a running count of captured frames.

Parameters:
PIX_W, 12, pixel data width
COORD_W, 11, width of X/Y coordinate outputs
LINE_LEN, 1280, active pixels per line; X wraps at LINE_LEN-1
FCNT_W, 32, frame counter width

Ports:
iCLK  input  1  pixel clock; all logic on rising edge
iRST  input  1  asynchronous, active-low reset
iDATA  input  PIX_W  raw sensor pixel
iFVAL  input  1  sensor frame valid
iLVAL  input  1  sensor line valid
iSTART  input  1  arm capture (level or pulse)
iEND  input  1  stop capture after current frame (level or pulse)
oDATA  output  PIX_W  captured pixel
oDVAL  output  1  oDATA/oX_Cont/oY_Cont valid
oX_Cont  output  COORD_W  column of pixel on oDATA
oY_Cont  output  COORD_W  row of pixel on oDATA
oFrame_Cont  output  FCNT_W  completed captured frames
oLine_err  output  1  one-cycle pulse: line ended short of LINE_LEN

Behaviour:
- Reset (iRST=0, async): state IDLE; all outputs 0; input registers, x_cnt and y_cnt 0; run flag 0.
- Stage 1 registers iDATA, iFVAL and iLVAL every cycle (fval_d, lval_d, data_d). A second copy fval_q supports edge detection.
- run flag: set by iSTART, cleared by iEND. If both are asserted in the same cycle, iEND wins and run=0.
- FSM:
  - IDLE -> ARMED when run=1.
  - ARMED: wait for rising edge of fval_d (fval_d=1, fval_q=0). On the edge -> ACTIVE; x_cnt=0, y_cnt=0. If run drops while ARMED -> IDLE.
  - ACTIVE: on falling edge of fval_d -> oFrame_Cont+1 (wraps modulo 2^FCNT_W), then ARMED if run=1, else IDLE.
  - Capture never begins mid-frame. If iFVAL is already high when armed, the block waits for the next frame.
  - iEND during ACTIVE does not truncate the frame; the current frame completes.
- Pixel valid: pv = ACTIVE & fval_d & lval_d.
- Stage 2 outputs, updated only when pv=1: oDATA<=data_d, oX_Cont<=x_cnt, oY_Cont<=y_cnt.
- oDVAL<=pv every cycle. oDATA/oX/oY hold their values when oDVAL=0.
- Latency: exactly 2 cycles from iDATA/iLVAL sampled to oDATA/oDVAL.
- Counters on pv:
  - If x_cnt==LINE_LEN-1: x_cnt<=0 and y_cnt+1.
  - Otherwise x_cnt+1.
- Short line: lval_d falls while ACTIVE with x_cnt!=0 -> x_cnt<=0, y_cnt+1, oLine_err pulses 1 cycle.
  - A lval_d fall with x_cnt==0 (line exactly LINE_LEN) has no extra effect; no double increment.
- y_cnt saturates at 2^COORD_W-1; it does not wrap.
- An iLVAL pulse outside iFVAL, or any pixel while not ACTIVE: ignored, oDVAL=0.
- Reset asserted mid-frame: everything clears immediately. After release, the block is IDLE and needs iSTART plus a fresh frame edge.

Decomposition:
- Shared package img_pkg holds:
  - PIX_W and COORD_W constants, shared with the greyscale/convolution stages.
  - cap_state_t enum {IDLE, ARMED, ACTIVE}.
- One natural sub-module: sig_edge, a registered rise/fall detector instanced for fval and lval.
- Counters and FSM stay in the top module.

Test Plan:
1. LINE_LEN=4. iSTART pulse, then one frame of 3 lines × 4 pixels, data=0x100+n. Expect:
   - 12 oDVAL beats, 2 cycles after the inputs.
   - (X,Y) = (0,0)..(3,0),(0,1)..(3,2), oDATA=0x100..0x10B.
   - oFrame_Cont=1 after iFVAL falls.
2. iSTART asserted while iFVAL is high mid-frame -> oDVAL=0 for the rest of that frame. Capture starts at the next frame with Y=0; oFrame_Cont counts only the complete frame.
3. LINE_LEN=4, second line only 2 pixels long -> oLine_err pulses once; the third line reports Y=2, X starting 0.
4. iEND pulsed mid-frame -> the current frame completes (all pixels valid, oFrame_Cont+1), then IDLE; the next frame produces no oDVAL. iSTART and iEND in the same cycle -> stays IDLE.
5. iRST low for 1 cycle mid-line -> all outputs 0 immediately (async). After release with no iSTART, no oDVAL across two frames.
6. iLVAL pulses while iFVAL=0 in ACTIVE/ARMED -> oDVAL stays 0 and counters are unchanged.
